// File: rtl/npc_unit.sv
// Next-PC selection for the F/D pipeline: resolves branches, jumps and register
// jumps in D, redirects fetch one edge later, and halts on a bad redirect.
module npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [2:0]  br_type,
  input  logic [2:0]  cmp_flags,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic        j_valid,
  input  logic [25:0] imm26,
  input  logic        jr_valid,
  input  logic [31:0] rs_val,
  output logic [31:0] pc_f,
  output logic        taken,
  output logic        addr_err,
  output logic [15:0] br_cnt,
  output logic [15:0] tk_cnt
);

  typedef enum logic {RUN, HALT_ERR} state_t;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLEZ = 3'b010;
  localparam logic [2:0] BGTZ = 3'b011;
  localparam logic [2:0] BLTZ = 3'b100;
  localparam logic [2:0] BGEZ = 3'b101;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        taken_reg;
  logic        addr_err_reg;
  logic [15:0] br_cnt_reg;
  logic [15:0] tk_cnt_reg;

  logic        flag_eq, flag_ltz, flag_eqz;
  logic        br_cond;
  logic        br_illegal;
  logic [31:0] pc_d_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        redirect;
  logic [31:0] target;
  logic        bad_redirect;

  assign {flag_eq, flag_ltz, flag_eqz} = cmp_flags;

  always_comb begin
    br_cond = 1'b0;
    case (br_type)
      BEQ:     br_cond = flag_eq;
      BNE:     br_cond = !flag_eq;
      BLEZ:    br_cond = flag_ltz | flag_eqz;
      BGTZ:    br_cond = !flag_ltz & !flag_eqz;
      BLTZ:    br_cond = flag_ltz;
      BGEZ:    br_cond = !flag_ltz;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_illegal = br_valid && (br_type[2:1] == 2'b11);
  assign pc_d_plus4 = pc_d + 32'd4;
  assign br_target  = pc_d_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target   = {pc_d_plus4[31:28], imm26, 2'b00};

  // Priority: register jump, then direct jump, then a taken branch.
  always_comb begin
    redirect = 1'b0;
    target   = 32'd0;
    if (jr_valid) begin
      redirect = 1'b1;
      target   = rs_val;
    end else if (j_valid) begin
      redirect = 1'b1;
      target   = j_target;
    end else if (br_valid && !br_illegal && br_cond) begin
      redirect = 1'b1;
      target   = br_target;
    end
  end

  assign bad_redirect = br_illegal || (redirect && (target[1:0] != 2'b00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      taken_reg    <= 1'b0;
      addr_err_reg <= 1'b0;
      br_cnt_reg   <= 16'd0;
      tk_cnt_reg   <= 16'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (!stall) begin
            if (bad_redirect) begin
              // Abort the transfer entirely: fetch and counters stay put.
              state_reg    <= HALT_ERR;
              addr_err_reg <= 1'b1;
              taken_reg    <= 1'b0;
            end else begin
              pc_reg    <= redirect ? target : pc_reg + 32'd4;
              taken_reg <= redirect;
              if (br_valid && (br_cnt_reg != 16'hFFFF))
                br_cnt_reg <= br_cnt_reg + 16'd1;
              if (redirect && (tk_cnt_reg != 16'hFFFF))
                tk_cnt_reg <= tk_cnt_reg + 16'd1;
            end
          end
        end
        default: begin
          taken_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pc_f     = pc_reg;
  assign taken    = taken_reg;
  assign addr_err = addr_err_reg;
  assign br_cnt   = br_cnt_reg;
  assign tk_cnt   = tk_cnt_reg;

endmodule

// File: doc/npc_unit.md
NPC_UNIT -- requirements
Module: npc_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_3000, the fetch address loaded on reset.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port stall, input, 1; when high, the F/D pipeline is frozen by hazard control.
REQ-005 The module SHALL have port br_valid, input, 1; a conditional branch sits in D.
REQ-006 The module SHALL have port br_type, input, 3, with codes 000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ; 110 and 111 are illegal.
REQ-007 The module SHALL have port cmp_flags, input, 3, as {eq, ltz, eqz}: rs==rt, rs<0 signed, rs==0, from the D-stage comparator.
REQ-008 The module SHALL have port pc_d, input, 32, the PC of the instruction in D.
REQ-009 The module SHALL have port imm16, input, 16, the branch offset in words.
REQ-010 The module SHALL have port j_valid, input, 1, for J or JAL in D, and port imm26, input, 26, the jump index.
REQ-011 The module SHALL have port jr_valid, input, 1, for JR or JALR in D, and port rs_val, input, 32, the forwarded rs value.
REQ-012 The module SHALL have port pc_f, output, 32, the current fetch address.
REQ-013 The module SHALL have port taken, output, 1, a registered pulse meaning the previous D-stage control transfer redirected fetch.
REQ-014 The module SHALL have port addr_err, output, 1, a sticky flag for a misaligned or illegal redirect target.
REQ-015 The module SHALL have ports br_cnt and tk_cnt, output, 16 each, the saturating counts of resolved branches and taken transfers.

Function
REQ-016 Branch condition: BEQ when eq, BNE when !eq, BLEZ when ltz|eqz, BGTZ when !ltz&!eqz, BLTZ when ltz, BGEZ when !ltz.
REQ-017 Branch target SHALL be pc_d + 4 + (sign-extended imm16 << 2), computed modulo 2^32 with wrap-around allowed.
REQ-018 J target SHALL be {pc_d+4 [31:28], imm26, 2'b00}, and JR target SHALL be rs_val.
REQ-019 Redirect priority SHALL be jr_valid, then j_valid, then a taken br_valid, then sequential fetch; simultaneous valids SHALL obey this priority without error.
REQ-020 The next PC SHALL be the selected target when a redirect is active, otherwise pc_f + 4; the delay slot is the instruction already in F, so no flush occurs.
REQ-021 While stall is high: pc_f, taken, and both counters SHALL hold; addr_err SHALL NOT be set; the branch is re-evaluated when stall drops.
REQ-022 The state machine SHALL have states RUN, HALT_ERR.
- RUN to HALT_ERR: an unstalled redirect with target[1:0] != 00, or br_valid with an illegal br_type.
- In HALT_ERR, pc_f SHALL freeze, taken SHALL stay 0, and the counters SHALL freeze; only reset exits.
REQ-023 On the error edge, pc_f SHALL NOT load the bad target; addr_err SHALL go 1 on the same edge.
REQ-024 br_cnt SHALL increment once per unstalled br_valid cycle in RUN; tk_cnt SHALL increment per unstalled redirect (jump or taken branch); both SHALL saturate at 16'hFFFF.
REQ-025 taken SHALL be 1 in the cycle after an unstalled redirect edge, otherwise 0.
REQ-026 The latency from D-stage resolution to the redirected pc_f SHALL be one clock edge.

Reset
REQ-027 Asserting reset SHALL immediately force pc_f=RESET_PC, taken=0, addr_err=0, br_cnt=0, tk_cnt=0, state=RUN, regardless of clk.
REQ-028 Reset asserted mid-redirect SHALL discard the redirect; the first edge after deassertion SHALL fetch RESET_PC+4 if no redirect is active.

Verification
REQ-029 Sequential fetch: release reset with no valids for 3 cycles -> pc_f = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-030 BEQ taken: pc_d=0x3004, imm16=0xFFFF, eq=1 -> next pc_f=0x3004, taken=1, br_cnt=1, tk_cnt=1.
REQ-031 BGTZ not taken with ltz=0, eqz=1 -> pc_f+4, taken=0, br_cnt increments, tk_cnt unchanged.
REQ-032 Priority: jr_valid, j_valid, and br_valid all asserted with rs_val=0x4000 -> pc_f=0x4000; jr_valid with stall=1 for 2 cycles -> pc_f holds, then 0x4000 after stall drops.
REQ-033 Error: jr_valid with rs_val=0x4002 -> addr_err=1, pc_f holds; further stimulus causes no change; async reset mid-cycle -> all outputs at reset values at once.
REQ-034 Saturation: force 65,536 taken branches -> tk_cnt=0xFFFF and stays at that value.
